// File: rtl/aes_word_serializer.sv
// aes_word_serializer: splits one 128-bit AES block into four 32-bit bus words.
// Each word gets a setup phase with bus_cs low, then a chip-select phase with bus_cs high until bus_ack.
// Ports:
//   clk, rst_n                  - clock and synchronous active-low reset
//   blk_in, blk_valid, blk_ready - block input handshake
//   word_out, bus_cs, bus_ack   - word and chip-select to the bus driver, acknowledge from the consumer
//   word_idx                    - index of the word currently on word_out
//   done                        - one-cycle pulse after the last word is acknowledged
//   timeout_err, clr_err        - sticky acknowledge-timeout flag and its clear
// Optional macro AES_SER_LSW_FIRST_EN: send the least significant word first.
module aes_word_serializer #(
    parameter int BLOCK_W      = 128,
    parameter int WORD_W       = 32,
    parameter int SETUP_CYCLES = 1,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic               blk_valid,
    output logic               blk_ready,
    output logic [WORD_W-1:0]  word_out,
    output logic               bus_cs,
    input  logic               bus_ack,
    output logic [1:0]         word_idx,
    output logic               done,
    output logic               timeout_err,
    input  logic               clr_err
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRIVE,
        TURN
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [9:0] TO_LAST    = 10'(ACK_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [BLOCK_W-1:0] shadow, shadow_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [3:0]         scnt, scnt_nxt;
    logic [9:0]         tcnt, tcnt_nxt;
    logic               err_set;

    logic               ready_nxt;
    logic               cs_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic [WORD_W-1:0]  word_sel;
    logic [WORD_W-1:0]  word_nxt;

    // State register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            idx         <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            blk_ready   <= 1'b1;
            word_out    <= '0;
            bus_cs      <= 1'b0;
            word_idx    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            idx         <= idx_nxt;
            scnt        <= scnt_nxt;
            tcnt        <= tcnt_nxt;
            blk_ready   <= ready_nxt;
            word_out    <= word_nxt;
            bus_cs      <= cs_nxt;
            word_idx    <= idx_nxt;
            done        <= done_nxt;
            timeout_err <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        idx_nxt    = idx;
        scnt_nxt   = scnt;
        tcnt_nxt   = tcnt;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                idx_nxt = '0;
                if (blk_valid && blk_ready) begin
                    shadow_nxt = blk_in;
                    scnt_nxt   = '0;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                if (scnt == SETUP_LAST) begin
                    tcnt_nxt  = '0;
                    state_nxt = DRIVE;
                end else begin
                    scnt_nxt = scnt + 4'd1;
                end
            end
            DRIVE: begin
                // An ack arriving on the expiry cycle still counts as an ack
                if (bus_ack) begin
                    if (idx == 2'd3) begin
                        state_nxt = TURN;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        scnt_nxt  = '0;
                        state_nxt = SETUP;
                    end
                end else if (tcnt == TO_LAST) begin
                    err_set   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 10'd1;
                end
            end
            TURN: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word selection; uses next-cycle shadow so word 0 appears right after capture
    always_comb begin
        word_sel = '0;
        unique case (idx_nxt)
`ifdef AES_SER_LSW_FIRST_EN
            2'd0: word_sel = shadow_nxt[WORD_W-1:0];
            2'd1: word_sel = shadow_nxt[2*WORD_W-1:WORD_W];
            2'd2: word_sel = shadow_nxt[3*WORD_W-1:2*WORD_W];
            2'd3: word_sel = shadow_nxt[4*WORD_W-1:3*WORD_W];
`else
            2'd0: word_sel = shadow_nxt[4*WORD_W-1:3*WORD_W];
            2'd1: word_sel = shadow_nxt[3*WORD_W-1:2*WORD_W];
            2'd2: word_sel = shadow_nxt[2*WORD_W-1:WORD_W];
            2'd3: word_sel = shadow_nxt[WORD_W-1:0];
`endif
            default: word_sel = '0;
        endcase
    end

    // Output decode from the next state, registered above.
    // The word only changes on entry to SETUP, so bus_cs is low whenever word_out moves.
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        cs_nxt    = (state_nxt == DRIVE);
        done_nxt  = (state_nxt == TURN);
        word_nxt  = '0;
        if (state_nxt == SETUP || state_nxt == DRIVE) begin
            word_nxt = word_sel;
        end
        // Setting the error takes priority over clearing it
        err_nxt = err_set | (timeout_err & ~clr_err);
    end

endmodule
